// File: rtl/fence_flush_seq_pkg.sv
// Shared types for the fence/flush sequencer: TLB flush commands, FSM states, payloads.
package fence_flush_seq_pkg;

   localparam int unsigned XLEN     = 64;
   localparam int unsigned ASID_LEN = 16;
   localparam int unsigned VPN_LEN  = 27;
   localparam int unsigned VPN_LSB  = 12;

   typedef logic [ASID_LEN-1:0] asid_t;
   typedef logic [VPN_LEN-1:0]  vpn_t;

   // TLB flush command; NoFlush is the idle encoding
   typedef enum logic [2:0] {
      NoFlush,
      FlushAll,
      FlushASID,
      FlushPage,
      FlushPageASID
   } tlb_flush_e;

   typedef enum logic [2:0] {
      FENCE_IDLE,
      FENCE_DRAIN,
      FENCE_SYNC,
      FENCE_CLEAR,
      FENCE_TLBFL,
      FENCE_DONE
   } fence_seq_state_t;

   // Fence request captured at accept
   typedef struct packed {
      logic  is_sfence;
      logic  rs1_nz;
      logic  rs2_nz;
      vpn_t  vpn;
      asid_t asid;
   } fence_req_t;

   // Registered output bundle driven towards commit and the memory subsystem
   typedef struct packed {
      logic       ready;
      logic       synch;
      logic       clr_l1tlb;
      logic       clr_l2tlb;
      logic       clr_dmshr;
      tlb_flush_e flush_type;
      asid_t      asid;
      vpn_t       page;
      logic       done;
   } fence_out_t;

   localparam fence_out_t FENCE_OUT_RST = '{
      ready:      1'b1,
      synch:      1'b0,
      clr_l1tlb:  1'b0,
      clr_l2tlb:  1'b0,
      clr_dmshr:  1'b0,
      flush_type: NoFlush,
      asid:       '0,
      page:       '0,
      done:       1'b0
   };

endpackage

// File: rtl/fence_flush_seq_if.sv
// Commit and memory-subsystem signals seen by the fence sequencer.
interface fence_flush_seq_if;
   import fence_flush_seq_pkg::*;

   logic             fence_valid_i;
   logic             fence_ready_o;
   logic             fence_is_sfence_i;
   logic             rs1_nz_i;
   logic             rs2_nz_i;
   logic [XLEN-1:0]  vaddr_i;
   asid_t            asid_i;
   logic             abort_i;
   logic             lsq_empty_i;
   logic             synch_l1dc_l2c_o;
   logic             l2c_update_done_i;
   logic             clr_l1tlb_mshr_o;
   logic             clr_l2tlb_mshr_o;
   logic             clear_dmshr_dregs_o;
   tlb_flush_e       L1TLB_flush_type_o;
   tlb_flush_e       L2TLB_flush_type_o;
   asid_t            flush_asid_o;
   vpn_t             flush_page_o;
   logic             fence_done_o;
   logic             flush_o;
   logic             sync_timeout_o;

   // Sequencer side
   modport slave (
      input  fence_valid_i, fence_is_sfence_i, rs1_nz_i, rs2_nz_i, vaddr_i, asid_i,
             abort_i, lsq_empty_i, l2c_update_done_i,
      output fence_ready_o, synch_l1dc_l2c_o, clr_l1tlb_mshr_o, clr_l2tlb_mshr_o,
             clear_dmshr_dregs_o, L1TLB_flush_type_o, L2TLB_flush_type_o,
             flush_asid_o, flush_page_o, fence_done_o, flush_o, sync_timeout_o
   );

   // Commit / memory-subsystem side
   modport master (
      output fence_valid_i, fence_is_sfence_i, rs1_nz_i, rs2_nz_i, vaddr_i, asid_i,
             abort_i, lsq_empty_i, l2c_update_done_i,
      input  fence_ready_o, synch_l1dc_l2c_o, clr_l1tlb_mshr_o, clr_l2tlb_mshr_o,
             clear_dmshr_dregs_o, L1TLB_flush_type_o, L2TLB_flush_type_o,
             flush_asid_o, flush_page_o, fence_done_o, flush_o, sync_timeout_o
   );

endinterface

// File: rtl/fence_flush_seq_type_dec.sv
// Maps SFENCE.VMA qualifier presence (rs1/rs2 non-zero) to a TLB flush command.
module fence_flush_type_dec
   import fence_flush_seq_pkg::*;
(
   input  logic       rs1_nz_i,
   input  logic       rs2_nz_i,
   output tlb_flush_e flush_type_c_o
);

   // Qualifier pair selects the flush granularity
   always_comb begin
      flush_type_c_o = FlushAll;
      case ({rs1_nz_i, rs2_nz_i})
         2'b00:   flush_type_c_o = FlushAll;
         2'b01:   flush_type_c_o = FlushASID;
         2'b10:   flush_type_c_o = FlushPage;
         default: flush_type_c_o = FlushPageASID;
      endcase
   end

endmodule

// File: rtl/fence_flush_seq.sv
// FENCE.I / SFENCE.VMA sequencer: drain LSQ, sync D$ with L2, clear MSHRs, flush TLBs, ack commit.
module fence_flush_seq
   import fence_flush_seq_pkg::*;
#(
   parameter int unsigned SYNC_TIMEOUT = 1024
)
(
   input  logic             clk_i,
   input  logic             rst_n_i,
   fence_flush_seq_if.slave fif
);

   localparam int unsigned         CNT_W   = $clog2(SYNC_TIMEOUT);
   localparam logic [CNT_W-1:0]    CNT_MAX = CNT_W'(SYNC_TIMEOUT - 1);

   fence_seq_state_t state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   fence_req_t       req_q, req_d;
   logic             timeout_q, timeout_d;
   fence_out_t       out_q, out_d;
   tlb_flush_e       dec_type;

   // Only the VPN field of the rs1 value matters here
   logic unused_vaddr_bits;
   assign unused_vaddr_bits = ^{fif.vaddr_i[XLEN-1:VPN_LSB+VPN_LEN], fif.vaddr_i[VPN_LSB-1:0]};

   fence_flush_type_dec u_type_dec (
      .rs1_nz_i       (req_q.rs1_nz),
      .rs2_nz_i       (req_q.rs2_nz),
      .flush_type_c_o (dec_type)
   );

   // State, sync counter, latched request, sticky timeout and registered outputs
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q   <= FENCE_IDLE;
         cnt_q     <= '0;
         req_q     <= '0;
         timeout_q <= 1'b0;
         out_q     <= FENCE_OUT_RST;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         req_q     <= req_d;
         timeout_q <= timeout_d;
         out_q     <= out_d;
      end
   end

   // Next-state logic; abort only matters while draining, after that the fence is committed
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      req_d     = req_q;
      timeout_d = timeout_q;
      case (state_q)
         FENCE_IDLE: begin
            if (fif.fence_valid_i) begin
               req_d.is_sfence = fif.fence_is_sfence_i;
               req_d.rs1_nz    = fif.rs1_nz_i;
               req_d.rs2_nz    = fif.rs2_nz_i;
               req_d.vpn       = fif.vaddr_i[VPN_LSB +: VPN_LEN];
               req_d.asid      = fif.asid_i;
               state_d         = FENCE_DRAIN;
            end
         end
         FENCE_DRAIN: begin
            if (fif.abort_i) begin
               state_d = FENCE_IDLE;
            end else if (fif.lsq_empty_i) begin
               cnt_d   = '0;
               state_d = FENCE_SYNC;
            end
         end
         FENCE_SYNC: begin
            if (fif.l2c_update_done_i) begin
               cnt_d   = '0;
               state_d = FENCE_CLEAR;
            end else if (cnt_q == CNT_MAX) begin
               cnt_d     = '0;
               timeout_d = 1'b1;
               state_d   = FENCE_CLEAR;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         FENCE_CLEAR: state_d = req_q.is_sfence ? FENCE_TLBFL : FENCE_DONE;
         FENCE_TLBFL: state_d = FENCE_DONE;
         FENCE_DONE:  state_d = FENCE_IDLE;
         default:     state_d = FENCE_IDLE;
      endcase
   end

   // Output decode of the upcoming state, so every output leaves a flop
   always_comb begin
      out_d           = FENCE_OUT_RST;
      out_d.ready     = (state_d == FENCE_IDLE);
      out_d.synch     = (state_d == FENCE_SYNC);
      out_d.clr_l1tlb = (state_d == FENCE_CLEAR);
      out_d.clr_l2tlb = (state_d == FENCE_CLEAR);
      out_d.clr_dmshr = (state_d == FENCE_CLEAR) && req_q.is_sfence;
      out_d.done      = (state_d == FENCE_DONE);
      if (state_d == FENCE_TLBFL) begin
         out_d.flush_type = dec_type;
         out_d.asid       = req_q.asid;
         out_d.page       = req_q.vpn;
      end
   end

   assign fif.fence_ready_o       = out_q.ready;
   assign fif.synch_l1dc_l2c_o    = out_q.synch;
   assign fif.clr_l1tlb_mshr_o    = out_q.clr_l1tlb;
   assign fif.clr_l2tlb_mshr_o    = out_q.clr_l2tlb;
   assign fif.clear_dmshr_dregs_o = out_q.clr_dmshr;
   assign fif.L1TLB_flush_type_o  = out_q.flush_type;
   assign fif.L2TLB_flush_type_o  = out_q.flush_type;
   assign fif.flush_asid_o        = out_q.asid;
   assign fif.flush_page_o        = out_q.page;
   assign fif.fence_done_o        = out_q.done;
   assign fif.flush_o             = out_q.done;
   assign fif.sync_timeout_o      = timeout_q;

endmodule

// File: tb/tb_fence_flush_seq.sv
`timescale 1ns/1ps
// Directed bench for fence_flush_seq with a timeline-based reference model.
module tb_fence_flush_seq;
   import fence_flush_seq_pkg::*;

   localparam int unsigned T = 8;

   logic clk;
   logic rst_n;

   fence_flush_seq_if ffi ();

   fence_flush_seq #(.SYNC_TIMEOUT(T)) dut (
      .clk_i   (clk),
      .rst_n_i (rst_n),
      .fif     (ffi.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      bit         ready, synch, clr1, clr2, dmshr;
      tlb_flush_e t1, t2;
      asid_t      asid;
      vpn_t       page;
      bit         done, flush, tout;
   } exp_t;

   exp_t       exp;
   bit         exp_valid;
   bit         model_to;
   int         n_checks;
   int         n_err;
   int         m_lat, m_sync, m_clr, m_dmshr;
   tlb_flush_e m_type;
   vpn_t       m_page;
   asid_t      m_asid;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
      n_checks++;
      if (act !== want) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, want, $time);
      end
   endtask

   function automatic exp_t idle_exp();
      exp_t e;
      e.ready = 1'b1; e.synch = 1'b0; e.clr1 = 1'b0; e.clr2 = 1'b0; e.dmshr = 1'b0;
      e.t1 = NoFlush; e.t2 = NoFlush; e.asid = '0; e.page = '0;
      e.done = 1'b0; e.flush = 1'b0; e.tout = model_to;
      return e;
   endfunction

   function automatic tlb_flush_e flush_rule(input bit r1, input bit r2);
      if (!r1 && !r2) return FlushAll;
      if (!r1)        return FlushASID;
      if (!r2)        return FlushPage;
      return FlushPageASID;
   endfunction

   // Compare every output against the model on the falling edge
   always @(negedge clk) begin
      if (exp_valid) begin
         chk("ready",   64'(ffi.fence_ready_o),       64'(exp.ready));
         chk("synch",   64'(ffi.synch_l1dc_l2c_o),    64'(exp.synch));
         chk("clr_l1",  64'(ffi.clr_l1tlb_mshr_o),    64'(exp.clr1));
         chk("clr_l2",  64'(ffi.clr_l2tlb_mshr_o),    64'(exp.clr2));
         chk("dmshr",   64'(ffi.clear_dmshr_dregs_o), 64'(exp.dmshr));
         chk("l1type",  64'(ffi.L1TLB_flush_type_o),  64'(exp.t1));
         chk("l2type",  64'(ffi.L2TLB_flush_type_o),  64'(exp.t2));
         chk("asid",    64'(ffi.flush_asid_o),        64'(exp.asid));
         chk("page",    64'(ffi.flush_page_o),        64'(exp.page));
         chk("done",    64'(ffi.fence_done_o),        64'(exp.done));
         chk("flush",   64'(ffi.flush_o),             64'(exp.flush));
         chk("timeout", 64'(ffi.sync_timeout_o),      64'(exp.tout));
      end
   end

   task automatic quiet_inputs();
      ffi.fence_valid_i     = 1'b0;
      ffi.fence_is_sfence_i = 1'b0;
      ffi.rs1_nz_i          = 1'b0;
      ffi.rs2_nz_i          = 1'b0;
      ffi.vaddr_i           = '0;
      ffi.asid_i            = '0;
      ffi.abort_i           = 1'b0;
      ffi.lsq_empty_i       = 1'b0;
      ffi.l2c_update_done_i = 1'b0;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         quiet_inputs();
         exp       = idle_exp();
         exp_valid = 1'b1;
         @(negedge clk);
         @(posedge clk); #1;
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_ready"}, 64'(ffi.fence_ready_o),       64'd1);
      chk({tag, "_synch"}, 64'(ffi.synch_l1dc_l2c_o),    64'd0);
      chk({tag, "_clr"},   64'(ffi.clr_l1tlb_mshr_o),    64'd0);
      chk({tag, "_dmshr"}, 64'(ffi.clear_dmshr_dregs_o), 64'd0);
      chk({tag, "_type"},  64'(ffi.L2TLB_flush_type_o),  64'(NoFlush));
      chk({tag, "_page"},  64'(ffi.flush_page_o),        64'd0);
      chk({tag, "_done"},  64'(ffi.fence_done_o),        64'd0);
      chk({tag, "_tout"},  64'(ffi.sync_timeout_o),      64'd0);
   endtask

   // d: DRAIN cycles with LSQ busy; a: DRAIN cycle carrying abort (-1 none);
   // s: SYNC cycle where L2 done rises (-1 never); stop_at: cycle to hit reset (-1 none)
   task automatic run_fence(input bit sf, input bit r1, input bit r2,
                            input logic [63:0] va, input asid_t as,
                            input int d, input int a, input int s,
                            input bit hold_v, input bit late_abort, input int stop_at);
      bit   aborted, tout;
      int   ld, ls, t_sync, t_clear, t_tlb, t_done, n;
      exp_t e;
      aborted = (a >= 0) && (a <= d);
      ld      = aborted ? a + 1 : d + 1;
      if (s >= 0 && s < int'(T)) begin ls = s + 1; tout = 1'b0; end
      else                       begin ls = int'(T); tout = 1'b1; end
      t_sync  = ld;
      t_clear = ld + ls;
      t_tlb   = t_clear + 1;
      t_done  = t_clear + (sf ? 2 : 1);
      n       = aborted ? ld : t_done + 1;
      m_lat = 0; m_sync = 0; m_clr = 0; m_dmshr = 0;
      m_type = NoFlush; m_page = '0; m_asid = '0;

      // accept cycle
      quiet_inputs();
      ffi.fence_valid_i     = 1'b1;
      ffi.fence_is_sfence_i = sf;
      ffi.rs1_nz_i          = r1;
      ffi.rs2_nz_i          = r2;
      ffi.vaddr_i           = va;
      ffi.asid_i            = as;
      exp       = idle_exp();
      exp_valid = 1'b1;
      @(negedge clk);
      @(posedge clk); #1;

      // scramble payload so only the latched copy can be correct
      ffi.fence_is_sfence_i = ~sf;
      ffi.rs1_nz_i          = ~r1;
      ffi.rs2_nz_i          = ~r2;
      ffi.vaddr_i           = ~va;
      ffi.asid_i            = ~as;

      for (int k = 0; k < n; k++) begin
         ffi.fence_valid_i     = hold_v;
         ffi.lsq_empty_i       = (k >= d);
         ffi.abort_i           = (k == a) || (late_abort && k == t_sync);
         ffi.l2c_update_done_i = (s >= 0) && (k >= t_sync + s);
         e       = idle_exp();
         e.ready = 1'b0;
         e.synch = !aborted && k >= t_sync && k < t_clear;
         e.clr1  = !aborted && k == t_clear;
         e.clr2  = e.clr1;
         e.dmshr = e.clr1 && sf;
         if (!aborted && sf && k == t_tlb) begin
            e.t1   = flush_rule(r1, r2);
            e.t2   = e.t1;
            e.asid = as;
            e.page = va[38:12];
         end
         e.done  = !aborted && k == t_done;
         e.flush = e.done;
         e.tout  = model_to || (!aborted && tout && k >= t_clear);
         exp     = e;
         @(negedge clk);
         if (ffi.fence_done_o)        m_lat = k + 1;
         if (ffi.synch_l1dc_l2c_o)    m_sync++;
         if (ffi.clr_l1tlb_mshr_o)    m_clr++;
         if (ffi.clear_dmshr_dregs_o) m_dmshr++;
         if (ffi.L1TLB_flush_type_o != NoFlush) begin
            m_type = ffi.L1TLB_flush_type_o;
            m_page = ffi.flush_page_o;
            m_asid = ffi.flush_asid_o;
         end
         if (k == stop_at) begin
            exp_valid = 1'b0;
            quiet_inputs();
            #2 rst_n = 1'b0;
            #1 check_reset_outputs("midrst");
            @(negedge clk);
            rst_n    = 1'b1;
            model_to = 1'b0;
            @(posedge clk); #1;
            return;
         end
         @(posedge clk); #1;
      end
      if (!aborted && tout) model_to = 1'b1;
      ffi.fence_valid_i = 1'b0;
      ffi.abort_i       = 1'b0;
   endtask

   initial begin
      n_checks  = 0;
      n_err     = 0;
      exp_valid = 1'b0;
      model_to  = 1'b0;
      quiet_inputs();
      rst_n = 1'b0;
      #12;
      check_reset_outputs("por");
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
      idle(2);

      // FENCE.I with memory already quiet
      run_fence(1'b0, 1'b0, 1'b0, 64'h0, 16'h0, 0, -1, 0, 1'b0, 1'b0, -1);
      chk("fencei_latency", 64'(m_lat),   64'd4);
      chk("fencei_clr_cnt", 64'(m_clr),   64'd1);
      chk("fencei_dmshr",   64'(m_dmshr), 64'd0);
      chk("fencei_type",    64'(m_type),  64'(NoFlush));
      idle(2);

      // SFENCE with page and ASID qualifiers
      run_fence(1'b1, 1'b1, 1'b1, 64'h0000_0040_1234_5000, 16'h7, 0, -1, 0, 1'b0, 1'b0, -1);
      chk("sfence_latency", 64'(m_lat),   64'd5);
      chk("sfence_type",    64'(m_type),  64'(FlushPageASID));
      chk("sfence_page",    64'(m_page),  64'h4012345);
      chk("sfence_asid",    64'(m_asid),  64'h7);
      chk("sfence_dmshr",   64'(m_dmshr), 64'd1);
      idle(1);

      // abort during DRAIN cancels everything
      run_fence(1'b1, 1'b1, 1'b0, 64'h0000_0012_3456_7000, 16'h3, 10, 2, 0, 1'b0, 1'b0, -1);
      chk("abort_done", 64'(m_lat),  64'd0);
      chk("abort_sync", 64'(m_sync), 64'd0);
      chk("abort_clr",  64'(m_clr),  64'd0);
      idle(2);

      // abort in SYNC is ignored
      run_fence(1'b0, 1'b0, 1'b0, 64'h0, 16'h0, 1, -1, 2, 1'b0, 1'b1, -1);
      chk("lateabort_latency", 64'(m_lat),  64'd7);
      chk("lateabort_sync",    64'(m_sync), 64'd3);
      idle(1);

      // L2 never answers: timeout after T cycles of SYNC
      run_fence(1'b0, 1'b1, 1'b1, 64'h0, 16'h0, 0, -1, -1, 1'b0, 1'b0, -1);
      chk("timeout_sync",    64'(m_sync), 64'd8);
      chk("timeout_latency", 64'(m_lat),  64'd11);
      idle(3);
      chk("timeout_sticky", 64'(ffi.sync_timeout_o), 64'd1);

      // reset while in SYNC, then a fresh fence
      run_fence(1'b1, 1'b1, 1'b1, 64'h0000_0055_0000_1000, 16'h9, 0, -1, -1, 1'b0, 1'b0, 3);
      idle(1);
      run_fence(1'b0, 1'b0, 1'b0, 64'h0, 16'h0, 0, -1, 0, 1'b0, 1'b0, -1);
      chk("postrst_latency", 64'(m_lat), 64'd4);
      idle(1);

      // SFENCE FlushAll with valid held, then back-to-back FENCE.I
      run_fence(1'b1, 1'b0, 1'b0, 64'h0000_0001_0000_2000, 16'h5, 0, -1, 0, 1'b1, 1'b0, -1);
      chk("b2b_type",    64'(m_type), 64'(FlushAll));
      chk("b2b_latency", 64'(m_lat),  64'd5);
      run_fence(1'b0, 1'b0, 1'b0, 64'h0, 16'h0, 0, -1, 0, 1'b0, 1'b0, -1);
      chk("b2b_second_latency", 64'(m_lat), 64'd4);
      idle(2);

      exp_valid = 1'b0;
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

endmodule
